mlu_cmd_driver: RTL and testbench

- Initiator-side sequencer for the MLU compute core (start/A/B/N in, result/ready out).
- Accepts operand commands on a valid/ready stream and issues each command to the core.
- Waits for the core's completion and captures each 6-bit result into a small result FIFO.
- Drains the FIFO on a valid/ready output stream, so the core can be driven back-to-back by logic rather than by a testbench.

---
 rtl/mlu_pkg.sv | 21 ++
 rtl/mlu_res_fifo.sv | 68 ++++++
 rtl/mlu_cmd_driver.sv | 145 ++++++++++++++
 tb/tb_mlu_cmd_driver.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlu_pkg.sv
// Shared types for the MLU command driver.
// MLU_DRV_TIMEOUT_EN adds a timeout flag to each result entry.
package mlu_pkg;

  localparam int OPW  = 3;
  localparam int RESW = 6;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
`ifdef MLU_DRV_TIMEOUT_EN
    logic            timeout;
`endif
    logic [RESW-1:0] data;
  } res_entry_t;

endpackage

// File: rtl/mlu_res_fifo.sv
// Result FIFO for the MLU command driver.
// Synchronous DEPTH-entry queue with count, full and empty.
module mlu_res_fifo
  import mlu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  res_entry_t                 wdata,
  input  logic                       pop,
  output res_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  res_entry_t    mem_q [DEPTH];
  res_entry_t    mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wp_q] = wdata;
      wp_d        = wp_q + AW'(1);
    end
    if (pop) begin
      rp_d = rp_q + AW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign rdata = empty ? '0 : mem_q[rp_q];

endmodule

// File: rtl/mlu_cmd_driver.sv
// Command sequencer driving the MLU core and buffering its results.
// MLU_DRV_TIMEOUT_EN abandons a command after TIMEOUT_CYCLES in WAIT.
module mlu_cmd_driver
  import mlu_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_a,
  input  logic [OPW-1:0]  cmd_b,
  input  logic [OPW-1:0]  cmd_n,
  output logic            core_start,
  output logic [OPW-1:0]  core_a,
  output logic [OPW-1:0]  core_b,
  output logic [OPW-1:0]  core_n,
  input  logic            core_ready,
  input  logic [RESW-1:0] core_result,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RESW-1:0] res_data,
  output logic            res_timeout,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t         state_q, state_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [OPW-1:0] n_q, n_d;

  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  res_entry_t     push_data;
  res_entry_t     head;

`ifdef MLU_DRV_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tmo_q, tmo_d;
`endif

  assign cmd_ready = (state_q == IDLE) && !full;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    n_d       = n_q;
    push      = 1'b0;
    push_data = '0;
`ifdef MLU_DRV_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          n_d     = cmd_n;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // core_ready here is a stale level from the previous op
        state_d = WAIT;
`ifdef MLU_DRV_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT: begin
        if (core_ready) begin
          push           = 1'b1;
          push_data.data = core_result;
          state_d        = IDLE;
`ifdef MLU_DRV_TIMEOUT_EN
        end else if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          push              = 1'b1;
          push_data.timeout = 1'b1;
          state_d           = IDLE;
        end else begin
          tmo_d = tmo_q + TCW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
`ifdef MLU_DRV_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
`ifdef MLU_DRV_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign pop = !empty && res_ready;

  mlu_res_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(push_data),
    .pop  (pop),
    .rdata(head),
    .count(count),
    .full (full),
    .empty(empty)
  );

  assign core_start = (state_q == ISSUE);
  assign core_a     = a_q;
  assign core_b     = b_q;
  assign core_n     = n_q;
  assign res_valid  = !empty;
  assign res_data   = head.data;
`ifdef MLU_DRV_TIMEOUT_EN
  assign res_timeout = head.timeout;
`else
  assign res_timeout = 1'b0;
`endif
  assign busy = (state_q != IDLE) || (count != '0);

endmodule

// File: tb/tb_mlu_cmd_driver.sv
// Testbench for mlu_cmd_driver with a stub MLU core.
// Scoreboard checks operands at start and results at pop.
module tb_mlu_cmd_driver;
  import mlu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_a, cmd_b, cmd_n;
  logic       core_start;
  logic [2:0] core_a, core_b, core_n;
  logic       core_ready;
  logic [5:0] core_result;
  logic       res_valid, res_ready;
  logic [5:0] res_data;
  logic       res_timeout, busy;

  always #5 clk = ~clk;

  mlu_cmd_driver #(
    .DEPTH(4),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_n      (cmd_n),
    .core_start (core_start),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_n     (core_n),
    .core_ready (core_ready),
    .core_result(core_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_timeout(res_timeout),
    .busy       (busy)
  );

  function automatic logic [5:0] model(
    input logic [2:0] a, b, n);
    return {a, b} ^ {3'b000, n};
  endfunction

  // stub core: ready `delay` cycles after start, 0 = never
  int         delay = 1;
  bit         stale = 1'b0;
  bit         fixed = 1'b0;
  int         scnt;
  logic [5:0] sres;

  always @(posedge clk) begin
    if (reset) begin
      scnt <= 0;
      sres <= '0;
    end else if (core_start) begin
      scnt <= delay;
      sres <= fixed ? 6'd25 : model(core_a, core_b, core_n);
    end else if (scnt != 0) begin
      scnt <= scnt - 1;
    end
  end

  assign core_ready  = stale || (scnt == 1);
  assign core_result = sres;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event did not occur as required", nm);
  endtask

  int         cyc = 0;
  logic [5:0] qd[$];
  logic       qt[$];
  logic [8:0] qo[$];
  int         acc_c[$];
  int         starts = 0;
  int         accs = 0;
  int         rise_cyc = -1;
  logic       rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (core_start) begin
        starts++;
        if (qo.size() == 0) fail("start_unexpected");
        else chk("start_ops", {core_a, core_b, core_n},
                 qo.pop_front());
      end
      if (res_valid && res_ready) begin
        if (qd.size() == 0) fail("pop_unexpected");
        else begin
          chk("res_data", res_data, qd.pop_front());
          chk("res_timeout", res_timeout, qt.pop_front());
        end
      end
      if (res_valid && !rv_prev) rise_cyc = cyc;
    end
    rv_prev = res_valid;
  end

  task automatic send(input logic [2:0] a, b, n,
                      input logic [5:0] e,
                      input logic t);
    int k;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_n = n;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 300);
    if (!cmd_ready) begin
      fail("accept_timeout");
    end else begin
      qd.push_back(e);
      qt.push_back(t);
      qo.push_back({a, b, n});
      acc_c.push_back(cyc);
      accs++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((busy || qd.size() != 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_start", core_start, 0);
    chk("rst_ops", {core_a, core_b, core_n}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    qd.delete();
    qt.delete();
    qo.delete();
  endtask

  typedef struct {
    logic [2:0] a, b, n;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[6];
  int   a0, s0, acc0, k;
  bit   fdone;

  initial begin
    tbl[0] = '{3'd1, 3'd2, 3'd3, 6'd9};
    tbl[1] = '{3'd7, 3'd7, 3'd7, 6'd56};
    tbl[2] = '{3'd0, 3'd0, 3'd0, 6'd0};
    tbl[3] = '{3'd3, 3'd4, 3'd1, 6'd29};
    tbl[4] = '{3'd6, 3'd1, 3'd5, 6'd52};
    tbl[5] = '{3'd2, 3'd5, 3'd6, 6'd19};
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_n = '0;
    res_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_res_valid", res_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_start", core_start, 0);
    chk("init_ops", {core_a, core_b, core_n}, 0);
    chk("init_res_data", res_data, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // single command, core answers 3 cycles after start
    fixed = 1'b1;
    delay = 3;
    res_ready = 1'b1;
    s0 = starts;
    send(3'd5, 3'd5, 3'd4, 6'd25, 1'b0);
    cmd_valid = 1'b0;
    a0 = acc_c[acc_c.size()-1];
    wait_drain();
    chk("single_starts", starts - s0, 1);
    chk("single_latency", rise_cyc, a0 + 5);
    fixed = 1'b0;

    // back-to-back from the vector table
    delay = 1;
    acc_c.delete();
    s0 = starts;
    for (int i = 0; i < 6; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].n, tbl[i].exp, 1'b0);
    cmd_valid = 1'b0;
    wait_drain();
    chk("b2b_starts", starts - s0, 6);
    for (int i = 1; i < 6; i++)
      chk("b2b_period", acc_c[i] - acc_c[i-1], 3);

    // backpressure until the FIFO fills
    res_ready = 1'b0;
    acc0 = accs;
    fdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(3'(i), 3'(7 - i), 3'(i + 1),
               model(3'(i), 3'(7 - i), 3'(i + 1)), 1'b0);
        cmd_valid = 1'b0;
        fdone = 1'b1;
      end
    join_none
    repeat (40) @(negedge clk);
    chk("full_accepted", accs - acc0, 4);
    chk("full_cmd_ready", cmd_ready, 0);
    chk("full_res_valid", res_valid, 1);
    @(posedge clk);
    #1 res_ready = 1'b1;
    k = 0;
    while (!fdone && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (!fdone) fail("full_sender_timeout");
    #1;
    wait_drain();
    chk("full_accepted_all", accs - acc0, 6);

    // core_ready stuck high
    stale = 1'b1;
    acc_c.delete();
    for (int i = 0; i < 3; i++)
      send(3'(i + 2), 3'(i), 3'(5 - i),
           model(3'(i + 2), 3'(i), 3'(5 - i)), 1'b0);
    cmd_valid = 1'b0;
    wait_drain();
    chk("stale_period0", acc_c[1] - acc_c[0], 3);
    chk("stale_period1", acc_c[2] - acc_c[1], 3);
    stale = 1'b0;

    // core never answers
    delay = 0;
`ifdef MLU_DRV_TIMEOUT_EN
    send(3'd3, 3'd3, 3'd3, 6'd0, 1'b1);
    cmd_valid = 1'b0;
    a0 = acc_c[acc_c.size()-1];
    wait_drain();
    chk("tmo_latency", rise_cyc, a0 + 12);
    delay = 1;
    send(3'd4, 3'd2, 3'd1, model(3'd4, 3'd2, 3'd1), 1'b0);
    cmd_valid = 1'b0;
    wait_drain();
`else
    send(3'd3, 3'd3, 3'd3, 6'd0, 1'b0);
    cmd_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("hang_busy", busy, 1);
    chk("hang_res_valid", res_valid, 0);
    do_reset();
    delay = 1;
`endif

    // reset mid-WAIT with two results buffered
    res_ready = 1'b0;
    send(3'd1, 3'd6, 3'd2, model(3'd1, 3'd6, 3'd2), 1'b0);
    send(3'd5, 3'd3, 3'd7, model(3'd5, 3'd3, 3'd7), 1'b0);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 delay = 0;
    send(3'd7, 3'd1, 3'd4, model(3'd7, 3'd1, 3'd4), 1'b0);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_res_valid", res_valid, 1);
    chk("pre_rst_busy", busy, 1);
    do_reset();
    delay = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
